// File: rtl/alu_seq_datapath_if.sv
// Signal bundle for alu_seq_datapath: operation request, direct register access and status.
// The master drives requests and register writes; the slave is the datapath.
interface alu_seq_datapath_if #(
  parameter int WIDTH = 32,
  parameter int ADDRW = 4
);
  logic             start;
  logic [3:0]       op;
  logic [ADDRW-1:0] ra;
  logic [ADDRW-1:0] rb;
  logic [ADDRW-1:0] rc;
  logic             ba_zero;
  logic             ext_we;
  logic [ADDRW-1:0] ext_waddr;
  logic [WIDTH-1:0] ext_wdata;
  logic [ADDRW-1:0] ext_raddr;
  logic [WIDTH-1:0] ext_rdata;
  logic             busy;
  logic             done;
  logic             err_op;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] bus;
  logic             zflag;
  logic             nflag;

  modport master (
    output start, op, ra, rb, rc, ba_zero, ext_we, ext_waddr, ext_wdata, ext_raddr,
    input  ext_rdata, busy, done, err_op, hi, lo, bus, zflag, nflag
  );

  modport slave (
    input  start, op, ra, rb, rc, ba_zero, ext_we, ext_waddr, ext_wdata, ext_raddr,
    output ext_rdata, busy, done, err_op, hi, lo, bus, zflag, nflag
  );
endinterface

// File: rtl/alu_seq_datapath.sv
// Single-bus sequenced ALU datapath: register file, Y/Z latches, HI/LO and flags,
// walked through read-A, read-B/compute, write-back and finish phases.
//
// state | meaning
// IDLE  | accepts start and direct register writes; bus = 0
// TY    | bus = source A (or 0 in base-address mode), latched into Y
// TZ    | bus = source B, ALU result latched into Zlo/Zhi
// TWB   | bus = Zlo, written to destination with flags (and HI/LO for MUL)
// FIN   | done pulse (err_op for illegal ops); bus = 0
module alu_seq_datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int ADDRW = 4
) (
  input logic clock,
  input logic clear,
  alu_seq_datapath_if.slave io
);
  typedef enum logic [2:0] {IDLE, TY, TZ, TWB, FIN} state_t;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [3:0]       OP_MUL  = 4'd8;
  localparam logic [3:0]       OP_LAST = 4'd10;

  state_t             state;
  logic [3:0]         op_q;
  logic [ADDRW-1:0]   ra_q;
  logic [ADDRW-1:0]   rb_q;
  logic [ADDRW-1:0]   rc_q;
  logic               baz_q;
  logic [WIDTH-1:0]   regs [NREGS];
  logic [WIDTH-1:0]   y;
  logic [WIDTH-1:0]   zlo;
  logic [WIDTH-1:0]   zhi;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               zflag_q;
  logic               nflag_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic [WIDTH-1:0]          bus_v;
  logic [WIDTH-1:0]          sh;
  logic [2*WIDTH-1:0]        dbl;
  logic [2*WIDTH-1:0]        rot_r;
  logic [2*WIDTH-1:0]        rot_l;
  logic signed [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]          alu_lo;
  logic [WIDTH-1:0]          alu_hi;
  logic                      op_legal;

  assign op_legal = (op_q <= OP_LAST);

  always_comb begin
    bus_v = '0;
    case (state)
      TY:      bus_v = (baz_q && ra_q == '0) ? '0 : regs[ra_q];
      TZ:      bus_v = regs[rb_q];
      TWB:     bus_v = zlo;
      default: bus_v = '0;
    endcase
  end

  // Rotates take one half of the doubled operand shifted by the amount.
  always_comb begin
    sh     = bus_v % WIDTH_V;
    dbl    = {y, y};
    rot_r  = dbl >> sh;
    rot_l  = dbl << sh;
    prod   = $signed({{WIDTH{y[WIDTH-1]}}, y}) * $signed({{WIDTH{bus_v[WIDTH-1]}}, bus_v});
    alu_lo = '0;
    alu_hi = '0;
    case (op_q)
      4'd0:    alu_lo = y + bus_v;
      4'd1:    alu_lo = y - bus_v;
      4'd2:    alu_lo = y & bus_v;
      4'd3:    alu_lo = y | bus_v;
      4'd4:    alu_lo = y >> sh;
      4'd5:    alu_lo = y << sh;
      4'd6:    alu_lo = rot_r[WIDTH-1:0];
      4'd7:    alu_lo = rot_l[2*WIDTH-1:WIDTH];
      4'd8:    {alu_hi, alu_lo} = prod;
      4'd9:    alu_lo = '0 - bus_v;
      4'd10:   alu_lo = ~bus_v;
      default: alu_lo = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      baz_q   <= 1'b0;
      y       <= '0;
      zlo     <= '0;
      zhi     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zflag_q <= 1'b0;
      nflag_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.ext_we) regs[io.ext_waddr] <= io.ext_wdata;
          if (io.start) begin
            op_q   <= io.op;
            ra_q   <= io.ra;
            rb_q   <= io.rb;
            rc_q   <= io.rc;
            baz_q  <= io.ba_zero;
            busy_q <= 1'b1;
            state  <= TY;
          end
        end
        TY: begin
          y     <= bus_v;
          state <= TZ;
        end
        TZ: begin
          zlo   <= alu_lo;
          zhi   <= alu_hi;
          state <= TWB;
        end
        TWB: begin
          if (op_legal) begin
            regs[rc_q] <= bus_v;
            zflag_q    <= (zlo == '0);
            nflag_q    <= zlo[WIDTH-1];
            if (op_q == OP_MUL) begin
              hi_q <= zhi;
              lo_q <= zlo;
            end
          end
          done_q <= 1'b1;
          err_q  <= ~op_legal;
          state  <= FIN;
        end
        FIN: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.ext_rdata = regs[io.ext_raddr];
  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.err_op    = err_q;
  assign io.hi        = hi_q;
  assign io.lo        = lo_q;
  assign io.bus       = bus_v;
  assign io.zflag     = zflag_q;
  assign io.nflag     = nflag_q;
endmodule

// File: tb/tb_alu_seq_datapath.sv
// Directed bench for alu_seq_datapath: a table of single operations with
// hand-computed results, then sequences for base-address, illegal op, overlap and abort.
module tb_alu_seq_datapath;
  logic clock = 1'b0;
  logic clear = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  alu_seq_datapath_if #(.WIDTH(32), .ADDRW(4)) io ();

  alu_seq_datapath #(.WIDTH(32), .NREGS(16), .ADDRW(4)) dut (
    .clock(clock),
    .clear(clear),
    .io(io)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        n;
    logic [31:0] hi_v;
    logic [31:0] lo_v;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ext_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clock);
    io.ext_we    = 1'b1;
    io.ext_waddr = addr;
    io.ext_wdata = data;
    @(posedge clock);
    #1 io.ext_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] data);
    io.ext_raddr = addr;
    #1 data = io.ext_rdata;
  endtask

  task automatic start_op(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] rc, input logic baz);
    @(negedge clock);
    io.start   = 1'b1;
    io.op      = op;
    io.ra      = ra;
    io.rb      = rb;
    io.rc      = rc;
    io.ba_zero = baz;
    @(posedge clock);
    #1;
    io.start   = 1'b0;
    io.ba_zero = 1'b0;
  endtask

  // Counts falling edges after the start edge until done; 99 means it never came.
  task automatic wait_done(output int n);
    n = 0;
    while (1) begin
      @(negedge clock);
      n++;
      if (io.done) break;
      if (n >= 8) begin
        n = 99;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          n;
    int          dc;

    vt[0]  = '{4'd0,  32'd7,        32'd5,        32'd12,       1'b0, 1'b0, 32'h0,        32'h0};
    vt[1]  = '{4'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b1, 32'h0,        32'h0};
    vt[2]  = '{4'd0,  32'hFFFFFFFF, 32'd1,        32'h0,        1'b1, 1'b0, 32'h0,        32'h0};
    vt[3]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1, 32'h0,        32'h0};
    vt[4]  = '{4'd3,  32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[5]  = '{4'd4,  32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[6]  = '{4'd5,  32'h00000001, 32'd33,       32'h00000002, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[7]  = '{4'd6,  32'h00000001, 32'd1,        32'h80000000, 1'b0, 1'b1, 32'h0,        32'h0};
    vt[8]  = '{4'd7,  32'h80000001, 32'd4,        32'h00000018, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[9]  = '{4'd6,  32'h12345678, 32'd32,       32'h12345678, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[10] = '{4'd8,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[11] = '{4'd9,  32'd0,        32'd5,        32'hFFFFFFFB, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[12] = '{4'd10, 32'd0,        32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[13] = '{4'd8,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vt[14] = '{4'd8,  32'h00010000, 32'h00010000, 32'h0,        1'b1, 1'b0, 32'h00000001, 32'h0};
    vt[15] = '{4'd1,  32'd3,        32'd3,        32'h0,        1'b1, 1'b0, 32'h00000001, 32'h0};
    vt[16] = '{4'd9,  32'd0,        32'd0,        32'h0,        1'b1, 1'b0, 32'h00000001, 32'h0};

    io.start = 1'b0; io.op = '0; io.ra = '0; io.rb = '0; io.rc = '0; io.ba_zero = 1'b0;
    io.ext_we = 1'b0; io.ext_waddr = '0; io.ext_wdata = '0; io.ext_raddr = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;

    // Reset state
    chk("rst_busy", io.busy, 0);
    chk("rst_done", io.done, 0);
    chk("rst_err", io.err_op, 0);
    chk("rst_hi", io.hi, 0);
    chk("rst_lo", io.lo, 0);
    chk("rst_flags", {io.zflag, io.nflag}, 0);
    chk("rst_bus", io.bus, 0);
    for (int i = 0; i < 16; i += 5) begin
      rd(4'(i), d);
      chk("rst_reg", d, 0);
    end

    // Table of single operations: R1 op R2 -> R3
    for (int i = 0; i < 17; i++) begin
      ext_write(4'd1, vt[i].a);
      ext_write(4'd2, vt[i].b);
      start_op(vt[i].op, 4'd1, 4'd2, 4'd3, 1'b0);
      wait_done(n);
      chk("latency", n, 4);
      chk("err_op", io.err_op, 0);
      chk("busy_fin", io.busy, 1);
      rd(4'd3, d);
      chk("result", d, vt[i].res);
      chk("flags", {io.zflag, io.nflag}, {vt[i].z, vt[i].n});
      chk("hi", io.hi, vt[i].hi_v);
      chk("lo", io.lo, vt[i].lo_v);
    end
    @(negedge clock);
    chk("busy_idle", io.busy, 0);
    chk("bus_idle", io.bus, 0);

    // Base-address mode zeroes only source A
    ext_write(4'd0, 32'd100);
    ext_write(4'd5, 32'd4);
    start_op(4'd0, 4'd0, 4'd5, 4'd6, 1'b1);
    wait_done(n);
    rd(4'd6, d);
    chk("baz_on", d, 32'd4);
    start_op(4'd0, 4'd0, 4'd5, 4'd6, 1'b0);
    wait_done(n);
    rd(4'd6, d);
    chk("baz_off", d, 32'd104);
    rd(4'd0, d);
    chk("r0_read", d, 32'd100);

    // Zero result sets zflag, then an illegal op must leave it and R7 alone
    ext_write(4'd7, 32'd9);
    start_op(4'd1, 4'd6, 4'd6, 4'd8, 1'b0);
    wait_done(n);
    chk("pre_illegal_flags", {io.zflag, io.nflag}, 2'b10);
    start_op(4'd12, 4'd1, 4'd2, 4'd7, 1'b0);
    wait_done(n);
    chk("illegal_latency", n, 4);
    chk("illegal_err", {io.done, io.err_op}, 2'b11);
    rd(4'd7, d);
    chk("illegal_r7", d, 32'd9);
    chk("illegal_flags", {io.zflag, io.nflag}, 2'b10);
    @(negedge clock);
    chk("err_pulse", {io.done, io.err_op}, 2'b00);

    // Same register as both sources and destination
    ext_write(4'd9, 32'd3);
    start_op(4'd0, 4'd9, 4'd9, 4'd9, 1'b0);
    wait_done(n);
    rd(4'd9, d);
    chk("same_reg", d, 32'd6);

    // Direct write and start on the same edge: operation sees the new value
    @(negedge clock);
    io.ext_we = 1'b1; io.ext_waddr = 4'd10; io.ext_wdata = 32'd20;
    io.start = 1'b1; io.op = 4'd0; io.ra = 4'd10; io.rb = 4'd10; io.rc = 4'd11;
    @(posedge clock);
    #1;
    io.ext_we = 1'b0; io.start = 1'b0;
    wait_done(n);
    chk("wr_start_lat", n, 4);
    rd(4'd11, d);
    chk("wr_start_res", d, 32'd40);

    // Start in TY and direct write in TZ are both ignored
    ext_write(4'd1, 32'd7);
    ext_write(4'd2, 32'd5);
    start_op(4'd0, 4'd1, 4'd2, 4'd3, 1'b0);
    @(negedge clock);
    chk("bus_ty", io.bus, 32'd7);
    io.start = 1'b1; io.op = 4'd1; io.ra = 4'd2; io.rb = 4'd2; io.rc = 4'd5;
    @(posedge clock);
    #1 io.start = 1'b0;
    @(negedge clock);
    chk("bus_tz", io.bus, 32'd5);
    io.ext_we = 1'b1; io.ext_waddr = 4'd3; io.ext_wdata = 32'hDEAD;
    @(posedge clock);
    #1 io.ext_we = 1'b0;
    dc = 0;
    repeat (10) begin
      @(negedge clock);
      if (io.done) dc++;
    end
    chk("overlap_dones", dc, 1);
    rd(4'd3, d);
    chk("overlap_r3", d, 32'd12);
    rd(4'd5, d);
    chk("overlap_r5", d, 32'd4);
    chk("overlap_busy", io.busy, 0);

    // Clear during TZ aborts: no done, everything zero
    ext_write(4'd1, 32'h55);
    start_op(4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    chk("abort_busy", io.busy, 0);
    dc = 0;
    repeat (6) begin
      @(negedge clock);
      if (io.done || io.busy) dc++;
    end
    chk("abort_nodone", dc, 0);
    rd(4'd1, d);
    chk("abort_r1", d, 0);
    rd(4'd11, d);
    chk("abort_r11", d, 0);
    chk("abort_hilo", {io.hi, io.lo}, 0);
    chk("abort_flags", {io.zflag, io.nflag}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
